// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// State encoding, line levels and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int MAX_DATA_BITS = 9;

  // Callers zero-extend narrower words; padding zeros leave the XOR unchanged.
  function automatic logic parity_of(
    input logic [MAX_DATA_BITS-1:0] data,
    input logic                     odd
  );
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle.
// Restart holds the count at zero so the first bit of a frame is full length.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic restart,
  output logic o_bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_Clk) begin
    if (i_Rst || restart || o_bit_end) cnt <= '0;
    else                               cnt <= cnt + 1'b1;
  end

  assign o_bit_end = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity, stop bits.
// A one-word holding buffer lets the next frame follow with no idle gap.
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_serial,
  output logic                 o_tx_active,
  output logic                 o_tx_done
);

  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  state_t state, next_state;

  logic                 buf_full;
  logic [DATA_BITS-1:0] buf_data;
  logic [DATA_BITS-1:0] shift;
  logic                 par;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic                 bit_end;
  logic                 accept;
  logic                 frame_end;
  logic                 load;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .restart  (state == IDLE),
    .o_bit_end(bit_end)
  );

  assign o_tx_ready = !buf_full;
  assign accept     = i_tx_valid && o_tx_ready;
  assign frame_end  = (state == STOP) && bit_end
                   && (stop_idx == STOP_LAST);
  assign load       = buf_full && ((state == IDLE) || frame_end);

  always_ff @(posedge i_Clk) begin
    if (i_Rst) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (buf_full) next_state = START;
      START:  if (bit_end) next_state = DATA;
      DATA:
        if (bit_end && bit_idx == IDX_LAST)
          next_state = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) next_state = STOP;
      STOP:
        if (frame_end)
          next_state = buf_full ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_tx_serial = LINE_IDLE;
    unique case (state)
      START:   o_tx_serial = LINE_START;
      DATA:    o_tx_serial = shift[0];
      PARITY:  o_tx_serial = par;
      default: o_tx_serial = LINE_IDLE;
    endcase
    o_tx_active = (state != IDLE);
    o_tx_done   = frame_end;
  end

  // Accept needs an empty buffer and load needs a full one, so they never collide.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      buf_full <= 1'b0;
      buf_data <= '0;
    end else if (accept) begin
      buf_full <= 1'b1;
      buf_data <= i_tx_data;
    end else if (load) begin
      buf_full <= 1'b0;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      shift    <= '0;
      par      <= 1'b0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (load) begin
      shift    <= buf_data;
      par      <= parity_of(MAX_DATA_BITS'(buf_data), 1'(PARITY_ODD));
      bit_idx  <= '0;
      stop_idx <= 1'b0;
    end else if (bit_end) begin
      if (state == DATA) begin
        shift   <= shift >> 1;
        bit_idx <= (bit_idx == IDX_LAST) ? '0 : bit_idx + 1'b1;
      end
      if (state == STOP)
        stop_idx <= (stop_idx == STOP_LAST) ? 1'b0 : stop_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with three parameter sets.
// Instance 0 is 8E1, instance 1 is 8O1, instance 2 is 7N2.
module tb_uart_tx_framer;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic [1:0] sel = 2'd0;

  logic [2:0] ser, rdy, act, dn;
  logic       line, ready, active, done;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign line   = ser[sel];
  assign ready  = rdy[sel];
  assign active = act[sel];
  assign done   = dn[sel];

  uart_tx_framer #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_even (
    .i_Clk(clk), .i_Rst(rst),
    .i_tx_data(data), .i_tx_valid(valid && sel == 2'd0),
    .o_tx_ready(rdy[0]), .o_tx_serial(ser[0]),
    .o_tx_active(act[0]), .o_tx_done(dn[0])
  );

  uart_tx_framer #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(1)
  ) u_odd (
    .i_Clk(clk), .i_Rst(rst),
    .i_tx_data(data), .i_tx_valid(valid && sel == 2'd1),
    .o_tx_ready(rdy[1]), .o_tx_serial(ser[1]),
    .o_tx_active(act[1]), .o_tx_done(dn[1])
  );

  uart_tx_framer #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) u_7n2 (
    .i_Clk(clk), .i_Rst(rst),
    .i_tx_data(data[6:0]), .i_tx_valid(valid && sel == 2'd2),
    .o_tx_ready(rdy[2]), .o_tx_serial(ser[2]),
    .o_tx_active(act[2]), .o_tx_done(dn[2])
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Junk on the data bus while stalled proves only the accept-edge word is taken.
  task automatic push(input logic [7:0] w, output int waited);
    waited = 0;
    valid  = 1'b1;
    while (!ready && waited < 200) begin
      data = 8'($urandom);
      @(negedge clk);
      waited++;
    end
    chk("push_ready", 32'(ready), 1);
    data = w;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic expect_frame(input logic [11:0] bits, input int n,
                              input string tag);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < CPB; c++) begin
        chk($sformatf("%s_line_b%0d", tag, b), 32'(line), 32'(bits[b]));
        chk($sformatf("%s_act_b%0d", tag, b), 32'(active), 1);
        chk($sformatf("%s_done_b%0d", tag, b), 32'(done),
            32'((b == n - 1) && (c == CPB - 1)));
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_line", 32'(line), 1);
    chk("rst_ready", 32'(ready), 1);
    chk("rst_active", 32'(active), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_line_7n2", 32'(ser[2]), 1);

    // 8E1 single frame and load latency
    push(8'h55, w);
    chk("lat_idle", 32'(line), 1);
    chk("rdy_drop", 32'(ready), 0);
    @(negedge clk);
    chk("rdy_load", 32'(ready), 1);
    expect_frame({1'b0, 1'b1, 1'b0, 8'h55, 1'b0}, 11, "e55");
    chk("e55_idle_act", 32'(active), 0);
    chk("e55_idle_line", 32'(line), 1);

    // odd parity
    sel = 2'd1;
    push(8'h01, w);
    @(negedge clk);
    expect_frame({1'b0, 1'b1, 1'b0, 8'h01, 1'b0}, 11, "o01");
    push(8'h00, w);
    @(negedge clk);
    expect_frame({1'b0, 1'b1, 1'b1, 8'h00, 1'b0}, 11, "o00");

    // back-to-back frames with a held-off third word
    sel = 2'd0;
    push(8'hA3, w);
    @(negedge clk);
    fork
      begin
        expect_frame({1'b0, 1'b1, 1'b0, 8'hA3, 1'b0}, 11, "bA3");
        expect_frame({1'b0, 1'b1, 1'b0, 8'h3C, 1'b0}, 11, "b3C");
        expect_frame({1'b0, 1'b1, 1'b1, 8'h9B, 1'b0}, 11, "b9B");
      end
      begin
        push(8'h3C, w);
        chk("rdy_busy", 32'(ready), 0);
        push(8'h9B, w);
        chk("hold_off", 32'(w), 43);
      end
    join
    chk("b2b_idle_act", 32'(active), 0);

    // reset in the middle of data bit 3, with a word pending
    push(8'h55, w);
    @(negedge clk);
    push(8'hEE, w);
    repeat (16) @(negedge clk);
    chk("pre_rst_bit3", 32'(line), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_line", 32'(line), 1);
    chk("mid_rst_act", 32'(active), 0);
    chk("mid_rst_rdy", 32'(ready), 1);
    chk("mid_rst_done", 32'(done), 0);
    repeat (3) @(negedge clk);
    chk("mid_rst_stale", 32'(active), 0);
    push(8'hC4, w);
    @(negedge clk);
    expect_frame({1'b0, 1'b1, 1'b1, 8'hC4, 1'b0}, 11, "rC4");

    // 7N2: ten bits, two stop bits
    sel = 2'd2;
    push(8'h7F, w);
    @(negedge clk);
    expect_frame({2'b00, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, "n7F");
    chk("n7F_idle_act", 32'(active), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
